// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings for the multi-cycle MIPS control unit
//
// Purpose: opcode/funct constants, the FSM state encoding, the instruction
// class enum and the datapath select encodings used by multicycle_ctrl and
// instr_class_decode.
// Ports: none (package).
package mips_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    CLS_RTYPE = 3'd0,
    CLS_ORI   = 3'd1,
    CLS_LUI   = 3'd2,
    CLS_LW    = 3'd3,
    CLS_SW    = 3'd4,
    CLS_BEQ   = 3'd5,
    CLS_JAL   = 3'd6,
    CLS_JR    = 3'd7
  } cls_e;

  // pc_sel
  localparam logic [1:0] PC_SEL_PC4    = 2'd0;
  localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
  localparam logic [1:0] PC_SEL_JUMP   = 2'd2;
  localparam logic [1:0] PC_SEL_REG    = 2'd3;

  // reg_addr_op
  localparam logic [1:0] RA_RD = 2'd0;
  localparam logic [1:0] RA_RT = 2'd1;
  localparam logic [1:0] RA_31 = 2'd2;

  // reg_data_op
  localparam logic [2:0] RD_ALU = 3'd0;
  localparam logic [2:0] RD_DM  = 3'd1;
  localparam logic [2:0] RD_LUI = 3'd2;
  localparam logic [2:0] RD_PC4 = 3'd3;

  // alu_op
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_SLL = 3'd3;

  // alu_b_op
  localparam logic [2:0] ALUB_READ2 = 3'd0;
  localparam logic [2:0] ALUB_ZEXT  = 3'd1;
  localparam logic [2:0] ALUB_SEXT  = 3'd2;
  localparam logic [2:0] ALUB_SHAMT = 3'd3;

endpackage

// File: rtl/instr_class_decode.sv
// rtl/instr_class_decode.sv - opcode/funct to instruction class and ALU controls
//
// Purpose: purely combinational classification of the captured opcode/funct.
// Ports:
//   opcode_i    in  6  captured instr[31:26]
//   funct_i     in  6  captured instr[5:0]
//   cls_o       out 3  instruction class (cls_e)
//   alu_op_o    out 3  ALU operation for EXEC/MEM/WB
//   alu_b_op_o  out 3  ALU B operand select
//   a1_op_o     out 1  GRF A1 reads rt (sll)
//   illegal_o   out 1  opcode/funct not supported
module instr_class_decode
  import mips_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output cls_e       cls_o,
  output logic [2:0] alu_op_o,
  output logic [2:0] alu_b_op_o,
  output logic       a1_op_o,
  output logic       illegal_o
);

  always_comb begin
    cls_o      = CLS_RTYPE;
    alu_op_o   = ALU_ADD;
    alu_b_op_o = ALUB_READ2;
    a1_op_o    = 1'b0;
    illegal_o  = 1'b0;
    case (opcode_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADDU: alu_op_o = ALU_ADD;
          FN_SUBU: alu_op_o = ALU_SUB;
          FN_SLL: begin
            // shift source is rt, amount comes from shamt
            alu_op_o   = ALU_SLL;
            alu_b_op_o = ALUB_SHAMT;
            a1_op_o    = 1'b1;
          end
          FN_JR:   cls_o = CLS_JR;
          default: illegal_o = 1'b1;
        endcase
      end
      OP_ORI: begin
        cls_o      = CLS_ORI;
        alu_op_o   = ALU_OR;
        alu_b_op_o = ALUB_ZEXT;
      end
      OP_LUI: begin
        // result comes straight from {imm,16'b0}; ALU settings are don't-care
        cls_o      = CLS_LUI;
        alu_b_op_o = ALUB_ZEXT;
      end
      OP_LW: begin
        cls_o      = CLS_LW;
        alu_b_op_o = ALUB_SEXT;
      end
      OP_SW: begin
        cls_o      = CLS_SW;
        alu_b_op_o = ALUB_SEXT;
      end
      OP_BEQ: begin
        cls_o    = CLS_BEQ;
        alu_op_o = ALU_SUB;
      end
      OP_JAL:  cls_o = CLS_JAL;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit
//
// Purpose: sequences each instruction through the MIPS datapath and drives
// its select/enable lines; MEM stretches on mem_ready with a timeout.
// Optional feature macro: MULTICYCLE_CTRL_PERF_EN adds cycle_cnt/instr_cnt.
// Ports:
//   clk, reset (sync, active-high)
//   instr[31:0], alu_zero, mem_ready                           inputs
//   ir_en, pc_en, pc_sel[1:0], reg_write, reg_addr_op[1:0],
//   reg_data_op[2:0], a1_op, alu_op[2:0], alu_b_op[2:0],
//   mem_req, mem_write, err_illegal, err_timeout               outputs
//   cycle_cnt[31:0], instr_cnt[31:0]                           perf outputs
module multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic        ir_en,
  output logic        pc_en,
  output logic [1:0]  pc_sel,
  output logic        reg_write,
  output logic [1:0]  reg_addr_op,
  output logic [2:0]  reg_data_op,
  output logic        a1_op,
  output logic [2:0]  alu_op,
  output logic [2:0]  alu_b_op,
  output logic        mem_req,
  output logic        mem_write,
  output logic        err_illegal,
  output logic        err_timeout
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
`endif
);

  localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_e        state_q, state_d;
  logic [5:0]    opcode_q, funct_q;
  logic [CW-1:0] cnt_q, cnt_d;

  cls_e       cls;
  logic [2:0] dec_alu_op, dec_alu_b_op;
  logic       dec_a1_op, dec_illegal;
  logic       timed_out;

  // Only opcode and funct matter here; the rest of the word feeds the datapath.
  logic unused_instr;
  assign unused_instr = ^instr[25:6];

  instr_class_decode u_dec (
    .opcode_i   (opcode_q),
    .funct_i    (funct_q),
    .cls_o      (cls),
    .alu_op_o   (dec_alu_op),
    .alu_b_op_o (dec_alu_b_op),
    .a1_op_o    (dec_a1_op),
    .illegal_o  (dec_illegal)
  );

  assign timed_out = (MEM_TIMEOUT != 0) && (cnt_q == CW'(MEM_TIMEOUT));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ir_en       = 1'b0;
    pc_en       = 1'b0;
    pc_sel      = PC_SEL_PC4;
    reg_write   = 1'b0;
    reg_addr_op = RA_RD;
    reg_data_op = RD_ALU;
    a1_op       = 1'b0;
    alu_op      = ALU_ADD;
    alu_b_op    = ALUB_READ2;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    err_illegal = 1'b0;
    err_timeout = 1'b0;

    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      alu_op   = dec_alu_op;
      alu_b_op = dec_alu_b_op;
      a1_op    = dec_a1_op;
    end

    case (state_q)
      S_FETCH: begin
        ir_en   = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (dec_illegal) begin
          err_illegal = 1'b1;
          pc_en       = 1'b1;
          state_d     = S_FETCH;
        end else if (cls == CLS_JAL) begin
          reg_write   = 1'b1;
          reg_addr_op = RA_31;
          reg_data_op = RD_PC4;
          pc_en       = 1'b1;
          pc_sel      = PC_SEL_JUMP;
          state_d     = S_FETCH;
        end else if (cls == CLS_JR) begin
          pc_en   = 1'b1;
          pc_sel  = PC_SEL_REG;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cls == CLS_BEQ) begin
          pc_en   = 1'b1;
          pc_sel  = alu_zero ? PC_SEL_BRANCH : PC_SEL_PC4;
          state_d = S_FETCH;
        end else if (cls == CLS_LW || cls == CLS_SW) begin
          cnt_d   = '0;
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        // Timeout wins over a late ready: the request is already withdrawn.
        if (timed_out) begin
          err_timeout = 1'b1;
          pc_en       = 1'b1;
          state_d     = S_FETCH;
        end else begin
          mem_req   = 1'b1;
          mem_write = (cls == CLS_SW);
          if (mem_ready) begin
            if (cls == CLS_SW) begin
              pc_en   = 1'b1;
              state_d = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end else if (MEM_TIMEOUT != 0) begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_WB: begin
        reg_write   = 1'b1;
        pc_en       = 1'b1;
        reg_addr_op = (cls == CLS_RTYPE) ? RA_RD : RA_RT;
        reg_data_op = (cls == CLS_LW)  ? RD_DM  :
                      (cls == CLS_LUI) ? RD_LUI : RD_ALU;
        state_d     = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset masks everything, including an in-flight mem_req.
    if (reset) begin
      ir_en       = 1'b0;
      pc_en       = 1'b0;
      pc_sel      = PC_SEL_PC4;
      reg_write   = 1'b0;
      reg_addr_op = RA_RD;
      reg_data_op = RD_ALU;
      a1_op       = 1'b0;
      alu_op      = ALU_ADD;
      alu_b_op    = ALUB_READ2;
      mem_req     = 1'b0;
      mem_write   = 1'b0;
      err_illegal = 1'b0;
      err_timeout = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      opcode_q <= '0;
      funct_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_FETCH) begin
        opcode_q <= instr[31:26];
        funct_q  <= instr[5:0];
      end
    end
  end

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cycle_cnt_q, instr_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (pc_en) instr_cnt_q <= instr_cnt_q + 32'd1;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr = 32'h0;
  logic        alu_zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        ir_en, pc_en, reg_write, a1_op, mem_req, mem_write;
  logic        err_illegal, err_timeout;
  logic [1:0]  pc_sel, reg_addr_op;
  logic [2:0]  reg_data_op, alu_op, alu_b_op;

  multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr       (instr),
    .alu_zero    (alu_zero),
    .mem_ready   (mem_ready),
    .ir_en       (ir_en),
    .pc_en       (pc_en),
    .pc_sel      (pc_sel),
    .reg_write   (reg_write),
    .reg_addr_op (reg_addr_op),
    .reg_data_op (reg_data_op),
    .a1_op       (a1_op),
    .alu_op      (alu_op),
    .alu_b_op    (alu_b_op),
    .mem_req     (mem_req),
    .mem_write   (mem_write),
    .err_illegal (err_illegal),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    logic [20:0] out;
    string       tag;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  // {ir,pc_en,pc_sel,reg_write,reg_addr_op,reg_data_op,a1,alu_op,alu_b_op,mem_req,mem_write,err_ill,err_to}
  function automatic logic [20:0] pk(input logic ir, input logic pe, input logic [1:0] ps,
                                     input logic rw, input logic [1:0] ra, input logic [2:0] rd,
                                     input logic a1, input logic [2:0] alu, input logic [2:0] ab,
                                     input logic mr, input logic mw, input logic ei, input logic et);
    return {ir, pe, ps, rw, ra, rd, a1, alu, ab, mr, mw, ei, et};
  endfunction

  logic [20:0] act;
  logic        act_ev;
  assign act = {ir_en, pc_en, pc_sel, reg_write, reg_addr_op, reg_data_op, a1_op,
                alu_op, alu_b_op, mem_req, mem_write, err_illegal, err_timeout};
  assign act_ev = ir_en | pc_en | reg_write | mem_req | err_illegal | err_timeout;

  // Monitor: every cycle with a strobe active must match the next expected event.
  always @(negedge clk) begin
    if (act_ev) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got cyc=%0d out=%h, required no event", cyc, act);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.cyc != cyc || mon_e.out !== act) begin
          errors++;
          $display("FAIL %s: got cyc=%0d out=%h, required cyc=%0d out=%h",
                   mon_e.tag, cyc, act, mon_e.cyc, mon_e.out);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input string tag, input int c, input logic [20:0] v);
    exp_t e;
    e.cyc = c;
    e.out = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic chk_zero(input string tag);
    @(negedge clk);
    checks++;
    if (act !== 21'h0) begin
      errors++;
      $display("FAIL %s: got out=%h, required out=0", tag, act);
    end
  endtask

  int c;
  logic [20:0] fetch_v, memrd_v, memwr_v;

  initial begin
    fetch_v = pk(1,0,2'd0,0,2'd0,3'd0,0,3'd0,3'd0,0,0,0,0);
    memrd_v = pk(0,0,2'd0,0,2'd0,3'd0,0,3'd0,3'd2,1,0,0,0);
    memwr_v = pk(0,0,2'd0,0,2'd0,3'd0,0,3'd0,3'd2,1,1,0,0);

    step(2);
    chk_zero("reset_outputs_zero");
    step(1);
    reset = 1'b0;
    c = cyc;

    // addu $3,$1,$2
    instr = 32'h00221821;
    push("addu_fetch", c, fetch_v);
    push("addu_wb", c + 3, pk(0,1,2'd0,1,2'd0,3'd0,0,3'd0,3'd0,0,0,0,0));
    step(4); c = cyc;

    // lw $5,8($1), two wait cycles
    instr = 32'h8C250008;
    push("lw_fetch", c, fetch_v);
    push("lw_mem_wait1", c + 3, memrd_v);
    push("lw_mem_wait2", c + 4, memrd_v);
    push("lw_mem_ready", c + 5, memrd_v);
    push("lw_wb", c + 6, pk(0,1,2'd0,1,2'd1,3'd1,0,3'd0,3'd2,0,0,0,0));
    step(5); mem_ready = 1'b1;
    step(1); mem_ready = 1'b0;
    step(1); c = cyc;

    // beq taken
    instr = 32'h10220004; alu_zero = 1'b1;
    push("beq_taken_fetch", c, fetch_v);
    push("beq_taken", c + 2, pk(0,1,2'd1,0,2'd0,3'd0,0,3'd1,3'd0,0,0,0,0));
    step(3); c = cyc;

    // beq not taken
    alu_zero = 1'b0;
    push("beq_nt_fetch", c, fetch_v);
    push("beq_not_taken", c + 2, pk(0,1,2'd0,0,2'd0,3'd0,0,3'd1,3'd0,0,0,0,0));
    step(3); c = cyc;

    // jal
    instr = 32'h0C000100;
    push("jal_fetch", c, fetch_v);
    push("jal_decode", c + 1, pk(0,1,2'd2,1,2'd2,3'd3,0,3'd0,3'd0,0,0,0,0));
    step(2); c = cyc;

    // jr $31
    instr = 32'h03E00008;
    push("jr_fetch", c, fetch_v);
    push("jr_decode", c + 1, pk(0,1,2'd3,0,2'd0,3'd0,0,3'd0,3'd0,0,0,0,0));
    step(2); c = cyc;

    // ori $4,$1,0xff
    instr = 32'h342400FF;
    push("ori_fetch", c, fetch_v);
    push("ori_wb", c + 3, pk(0,1,2'd0,1,2'd1,3'd0,0,3'd2,3'd1,0,0,0,0));
    step(4); c = cyc;

    // lui $6,0x1234
    instr = 32'h3C061234;
    push("lui_fetch", c, fetch_v);
    push("lui_wb", c + 3, pk(0,1,2'd0,1,2'd1,3'd2,0,3'd0,3'd1,0,0,0,0));
    step(4); c = cyc;

    // sll $2,$3,4
    instr = 32'h00031100;
    push("sll_fetch", c, fetch_v);
    push("sll_wb", c + 3, pk(0,1,2'd0,1,2'd0,3'd0,1,3'd3,3'd3,0,0,0,0));
    step(4); c = cyc;

    // subu $3,$1,$2
    instr = 32'h00221823;
    push("subu_fetch", c, fetch_v);
    push("subu_wb", c + 3, pk(0,1,2'd0,1,2'd0,3'd0,0,3'd1,3'd0,0,0,0,0));
    step(4); c = cyc;

    // sw, ready on first MEM cycle
    instr = 32'hAC250004;
    push("sw_fetch", c, fetch_v);
    push("sw_mem_ready", c + 3, pk(0,1,2'd0,0,2'd0,3'd0,0,3'd0,3'd2,1,1,0,0));
    step(3); mem_ready = 1'b1;
    step(1); mem_ready = 1'b0; c = cyc;

    // sw, ready never comes: four MEM cycles then timeout
    push("sw_to_fetch", c, fetch_v);
    for (int i = 0; i < 4; i++) push("sw_to_mem", c + 3 + i, memwr_v);
    push("sw_timeout", c + 7, pk(0,1,2'd0,0,2'd0,3'd0,0,3'd0,3'd2,0,0,0,1));
    step(8); c = cyc;

    // illegal opcode 6'h3F
    instr = 32'hFC000000;
    push("ill_fetch", c, fetch_v);
    push("ill_decode", c + 1, pk(0,1,2'd0,0,2'd0,3'd0,0,3'd0,3'd0,0,0,1,0));
    step(2); c = cyc;

    // lw interrupted by reset while waiting in MEM
    instr = 32'h8C250008;
    push("lwrst_fetch", c, fetch_v);
    push("lwrst_mem1", c + 3, memrd_v);
    push("lwrst_mem2", c + 4, memrd_v);
    step(5); reset = 1'b1;
    chk_zero("reset_mid_mem_outputs_zero");
    step(1); reset = 1'b0; c = cyc;

    instr = 32'h00221821;
    push("post_reset_fetch", c, fetch_v);
    push("post_reset_addu_wb", c + 3, pk(0,1,2'd0,1,2'd0,3'd0,0,3'd0,3'd0,0,0,0,0));
    step(4);
    reset = 1'b1;
    step(2);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drained: got %0d pending, required 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
